// File: rtl/alu_issue_decoder.sv
// alu_issue_decoder: front end of the LEGv8 ALU datapath.
// This block accepts one 32-bit instruction per Instr_valid/Instr_ready handshake and
// decodes it on the accept edge, so every output comes straight from a flop.
// In the cycle after the accept, the block pulses Issue_valid together with
// ALU_control, ALUSrc, Sign_extend, the register addresses and the strobes.
// For CBZ/CBNZ, the Zero flag is sampled ZERO_LAT cycles after Issue_valid.
// The result is reported as a Branch_valid pulse with Branch_taken and Branch_offset.
//
// Parameters: DATA_W   - width of Sign_extend / Branch_offset
//             ZERO_LAT - Issue_valid to Zero-sample distance in cycles (1..4)
// Ports:      clk, rst_n (async active-low)
//             Instr_valid, Instr[31:0] / Instr_ready      - instruction handshake
//             Zero                                         - ALU zero flag
//             Issue_valid, ALU_control, ALUSrc, Sign_extend,
//             Rn_addr, Rm_addr, Rd_addr, Reg_write, Mem_read, Mem_write
//             Branch_valid, Branch_taken, Branch_offset
//             Illegal_instr - present only when ILLEGAL_TRAP_EN is defined
// Configuration macro: ILLEGAL_TRAP_EN
//   defined   : an unmatched opcode pulses Illegal_instr instead of issuing
//   undefined : an unmatched opcode issues as a NOP (ALU_control=0, no strobes)
module alu_issue_decoder #(
    parameter int DATA_W   = 32,
    parameter int ZERO_LAT = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              Instr_valid,
    input  logic [31:0]       Instr,
    output logic              Instr_ready,
    input  logic              Zero,
    output logic              Issue_valid,
    output logic [3:0]        ALU_control,
    output logic              ALUSrc,
    output logic [DATA_W-1:0] Sign_extend,
    output logic [4:0]        Rn_addr,
    output logic [4:0]        Rm_addr,
    output logic [4:0]        Rd_addr,
    output logic              Reg_write,
    output logic              Mem_read,
    output logic              Mem_write,
    output logic              Branch_valid,
    output logic              Branch_taken,
    output logic [DATA_W-1:0] Branch_offset
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic              Illegal_instr
`endif
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_WAIT    = 2'd2,
        S_RESOLVE = 2'd3
    } state_t;

    typedef struct packed {
        logic              legal;
        logic              is_cb;
        logic [3:0]        alu;
        logic              alusrc;
        logic [DATA_W-1:0] imm;
        logic [4:0]        rn;
        logic [4:0]        rm;
        logic [4:0]        rd;
        logic              rw;
        logic              mr;
        logic              mw;
    } dec_t;

    // Last WAIT count before RESOLVE; unused when ZERO_LAT is 1 (WAIT is skipped).
    localparam logic [1:0] WAIT_LAST = 2'((ZERO_LAT > 1) ? (ZERO_LAT - 2) : 0);

    // Wider opcode fields are tested first so that shorter ones never shadow them.
    function automatic dec_t decode(input logic [31:0] ins);
        dec_t d;
        d = '0;
        case (ins[31:21])
            11'b10001011000: begin d.legal = 1'b1; d.alu = 4'b0010; end
            11'b11001011000: begin d.legal = 1'b1; d.alu = 4'b1010; end
            11'b10001010000: begin d.legal = 1'b1; d.alu = 4'b0110; end
            11'b10101010000: begin d.legal = 1'b1; d.alu = 4'b0100; end
            11'b11001010000: begin d.legal = 1'b1; d.alu = 4'b1001; end
            default:         begin d.legal = 1'b0; end
        endcase
        if (d.legal) begin
            d.rm = ins[20:16];
            d.rn = ins[9:5];
            d.rd = ins[4:0];
            d.rw = 1'b1;
        end else if (ins[31:21] == 11'b11111000010) begin
            d.legal = 1'b1; d.alu = 4'b0010; d.alusrc = 1'b1;
            d.imm = {{(DATA_W-9){ins[20]}}, ins[20:12]};
            d.rn = ins[9:5]; d.rd = ins[4:0]; d.mr = 1'b1; d.rw = 1'b1;
        end else if (ins[31:21] == 11'b11111000000) begin
            d.legal = 1'b1; d.alu = 4'b0010; d.alusrc = 1'b1;
            d.imm = {{(DATA_W-9){ins[20]}}, ins[20:12]};
            d.rn = ins[9:5]; d.rm = ins[4:0]; d.mw = 1'b1;
        end else if ((ins[31:22] == 10'b1001000100) || (ins[31:22] == 10'b1101000100)) begin
            d.legal = 1'b1; d.alusrc = 1'b1;
            d.alu = ins[30] ? 4'b1010 : 4'b0010;
            d.imm = {{(DATA_W-12){1'b0}}, ins[21:10]};
            d.rn = ins[9:5]; d.rd = ins[4:0]; d.rw = 1'b1;
        end else if (ins[31:23] == 9'b110100101) begin
            d.legal = 1'b1; d.alu = 4'b1101; d.alusrc = 1'b1;
            d.imm = {{(DATA_W-16){1'b0}}, ins[20:5]};
            d.rd = ins[4:0]; d.rw = 1'b1;
        end else if (ins[31:25] == 7'b1011010) begin
            // CBZ (bit 24 = 0) / CBNZ (bit 24 = 1); the tested register sits in [4:0].
            d.legal = 1'b1; d.is_cb = 1'b1;
            d.alu = ins[24] ? 4'b0001 : 4'b0111;
            d.imm = {{(DATA_W-19){ins[23]}}, ins[23:5]};
            d.rn = ins[4:0];
        end else begin
            d = '0;
        end
        return d;
    endfunction

    state_t            state_q, state_d;
    logic [1:0]        cnt_q, cnt_d;
    logic              is_cb_q, is_cb_d;
    logic              instr_ready_q, instr_ready_d;
    logic              issue_valid_q, issue_valid_d;
    logic [3:0]        alu_q, alu_d;
    logic              alusrc_q, alusrc_d;
    logic [DATA_W-1:0] se_q, se_d;
    logic [4:0]        rn_q, rn_d, rm_q, rm_d, rd_q, rd_d;
    logic              reg_write_q, reg_write_d;
    logic              mem_read_q, mem_read_d;
    logic              mem_write_q, mem_write_d;
    logic              branch_valid_q, branch_valid_d;
    logic              branch_taken_q, branch_taken_d;
    logic [DATA_W-1:0] branch_offset_q, branch_offset_d;
    logic              illegal_q, illegal_d;
    logic              load_s, resolve_s;
    dec_t              dec_s;

    assign dec_s = decode(Instr);

    // Next-state and next-output logic for the accept/issue/wait/resolve sequence.
    always_comb begin
        state_d         = state_q;
        cnt_d           = cnt_q;
        is_cb_d         = is_cb_q;
        alu_d           = alu_q;
        alusrc_d        = alusrc_q;
        se_d            = se_q;
        rn_d            = rn_q;
        rm_d            = rm_q;
        rd_d            = rd_q;
        issue_valid_d   = 1'b0;
        reg_write_d     = 1'b0;
        mem_read_d      = 1'b0;
        mem_write_d     = 1'b0;
        branch_valid_d  = 1'b0;
        branch_taken_d  = branch_taken_q;
        branch_offset_d = branch_offset_q;
        illegal_d       = 1'b0;
        load_s          = 1'b0;
        resolve_s       = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (Instr_valid) begin
                    state_d = S_ISSUE;
`ifdef ILLEGAL_TRAP_EN
                    if (dec_s.legal) begin
                        load_s = 1'b1;
                    end else begin
                        is_cb_d   = 1'b0;
                        illegal_d = 1'b1;
                    end
`else
                    load_s = 1'b1;
`endif
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (is_cb_q) begin
                    if (ZERO_LAT == 1) begin
                        resolve_s = 1'b1;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 2'd0;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    resolve_s = 1'b1;
                end else begin
                    cnt_d = cnt_q + 2'd1;
                end
            end
            S_RESOLVE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        // An unmatched opcode reaches here as an all-zero decode, i.e. a NOP issue.
        if (load_s) begin
            is_cb_d       = dec_s.is_cb;
            alu_d         = dec_s.alu;
            alusrc_d      = dec_s.alusrc;
            se_d          = dec_s.imm;
            rn_d          = dec_s.rn;
            rm_d          = dec_s.rm;
            rd_d          = dec_s.rd;
            reg_write_d   = dec_s.rw;
            mem_read_d    = dec_s.mr;
            mem_write_d   = dec_s.mw;
            issue_valid_d = 1'b1;
        end else begin
            issue_valid_d = 1'b0;
        end
        // Zero is captured on the edge that enters RESOLVE.
        if (resolve_s) begin
            state_d         = S_RESOLVE;
            branch_valid_d  = 1'b1;
            branch_taken_d  = Zero;
            branch_offset_d = {se_q[DATA_W-3:0], 2'b00};
        end else begin
            branch_valid_d = 1'b0;
        end
        instr_ready_d = (state_d == S_IDLE);
    end

    // State and registered outputs; reset forces IDLE with only Instr_ready high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q         <= S_IDLE;
            cnt_q           <= 2'd0;
            is_cb_q         <= 1'b0;
            instr_ready_q   <= 1'b1;
            issue_valid_q   <= 1'b0;
            alu_q           <= 4'd0;
            alusrc_q        <= 1'b0;
            se_q            <= '0;
            rn_q            <= 5'd0;
            rm_q            <= 5'd0;
            rd_q            <= 5'd0;
            reg_write_q     <= 1'b0;
            mem_read_q      <= 1'b0;
            mem_write_q     <= 1'b0;
            branch_valid_q  <= 1'b0;
            branch_taken_q  <= 1'b0;
            branch_offset_q <= '0;
            illegal_q       <= 1'b0;
        end else begin
            state_q         <= state_d;
            cnt_q           <= cnt_d;
            is_cb_q         <= is_cb_d;
            instr_ready_q   <= instr_ready_d;
            issue_valid_q   <= issue_valid_d;
            alu_q           <= alu_d;
            alusrc_q        <= alusrc_d;
            se_q            <= se_d;
            rn_q            <= rn_d;
            rm_q            <= rm_d;
            rd_q            <= rd_d;
            reg_write_q     <= reg_write_d;
            mem_read_q      <= mem_read_d;
            mem_write_q     <= mem_write_d;
            branch_valid_q  <= branch_valid_d;
            branch_taken_q  <= branch_taken_d;
            branch_offset_q <= branch_offset_d;
            illegal_q       <= illegal_d;
        end
    end

    assign Instr_ready   = instr_ready_q;
    assign Issue_valid   = issue_valid_q;
    assign ALU_control   = alu_q;
    assign ALUSrc        = alusrc_q;
    assign Sign_extend   = se_q;
    assign Rn_addr       = rn_q;
    assign Rm_addr       = rm_q;
    assign Rd_addr       = rd_q;
    assign Reg_write     = reg_write_q;
    assign Mem_read      = mem_read_q;
    assign Mem_write     = mem_write_q;
    assign Branch_valid  = branch_valid_q;
    assign Branch_taken  = branch_taken_q;
    assign Branch_offset = branch_offset_q;
`ifdef ILLEGAL_TRAP_EN
    assign Illegal_instr = illegal_q;
`endif

endmodule

// File: tb/tb_alu_issue_decoder.sv
// Scoreboard bench for alu_issue_decoder: dut 0 uses ZERO_LAT=1, dut 1 uses ZERO_LAT=3.
module tb_alu_issue_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  iv, zero;
    logic [31:0] ins [2];
    logic [1:0]  rdy, isv, src, rw, mr, mw, bv, bt, ill;
    logic [3:0]  alu [2];
    logic [31:0] se [2];
    logic [31:0] bo [2];
    logic [4:0]  rn [2];
    logic [4:0]  rm [2];
    logic [4:0]  rd [2];
    int cyc = 0;
    int checks = 0;
    int fails = 0;

    typedef struct {
        string       tag;
        int          kind;   // 0 issue, 1 branch, 2 illegal
        int          cyc;
        logic [3:0]  alu;
        logic        src;
        logic [31:0] se;
        logic        chk_se;
        logic [4:0]  rn, rm, rd;
        logic        rw, mr, mw, taken;
        logic [31:0] off;
    } item_t;

    typedef struct {
        string       tag;
        logic [31:0] instr;
        logic        zero, illegal, br;
        item_t       e;
    } vec_t;

    item_t q0[$];
    item_t q1[$];
    vec_t  vq[$];

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    alu_issue_decoder #(.DATA_W(32), .ZERO_LAT(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .Instr_valid(iv[0]), .Instr(ins[0]), .Instr_ready(rdy[0]),
        .Zero(zero[0]), .Issue_valid(isv[0]), .ALU_control(alu[0]), .ALUSrc(src[0]),
        .Sign_extend(se[0]), .Rn_addr(rn[0]), .Rm_addr(rm[0]), .Rd_addr(rd[0]),
        .Reg_write(rw[0]), .Mem_read(mr[0]), .Mem_write(mw[0]), .Branch_valid(bv[0]),
        .Branch_taken(bt[0]), .Branch_offset(bo[0])
`ifdef ILLEGAL_TRAP_EN
        , .Illegal_instr(ill[0])
`endif
    );

    alu_issue_decoder #(.DATA_W(32), .ZERO_LAT(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .Instr_valid(iv[1]), .Instr(ins[1]), .Instr_ready(rdy[1]),
        .Zero(zero[1]), .Issue_valid(isv[1]), .ALU_control(alu[1]), .ALUSrc(src[1]),
        .Sign_extend(se[1]), .Rn_addr(rn[1]), .Rm_addr(rm[1]), .Rd_addr(rd[1]),
        .Reg_write(rw[1]), .Mem_read(mr[1]), .Mem_write(mw[1]), .Branch_valid(bv[1]),
        .Branch_taken(bt[1]), .Branch_offset(bo[1])
`ifdef ILLEGAL_TRAP_EN
        , .Illegal_instr(ill[1])
`endif
    );

`ifndef ILLEGAL_TRAP_EN
    assign ill = 2'b00;
`endif

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic add_vec(input string tag, input logic [31:0] instr, input logic z,
                           input logic illegal, input logic br, input logic [3:0] a,
                           input logic s, input logic [31:0] imm, input logic cse,
                           input logic [4:0] n, input logic [4:0] m, input logic [4:0] d,
                           input logic w, input logic r, input logic st,
                           input logic tk, input logic [31:0] off);
        vec_t v;
        v.tag = tag; v.instr = instr; v.zero = z; v.illegal = illegal; v.br = br;
        v.e.tag = tag; v.e.kind = 0; v.e.cyc = 0; v.e.alu = a; v.e.src = s; v.e.se = imm;
        v.e.chk_se = cse; v.e.rn = n; v.e.rm = m; v.e.rd = d; v.e.rw = w; v.e.mr = r;
        v.e.mw = st; v.e.taken = tk; v.e.off = off;
        vq.push_back(v);
    endtask

    task automatic chk_reset(input int id, input string nm);
        chk({nm, "_ready"}, {31'd0, rdy[id]}, 32'd1);
        chk({nm, "_pulses"}, {26'd0, isv[id], rw[id], mr[id], mw[id], bv[id], ill[id]}, 32'd0);
        chk({nm, "_alu_src_taken"}, {26'd0, alu[id], src[id], bt[id]}, 32'd0);
        chk({nm, "_addrs"}, {17'd0, rn[id], rm[id], rd[id]}, 32'd0);
        chk({nm, "_sign_extend"}, se[id], 32'd0);
        chk({nm, "_offset"}, bo[id], 32'd0);
    endtask

    // Drive one instruction on dut id; push the expected responses once it is accepted.
    task automatic send(input int id, input vec_t v, output int acc);
        item_t e;
        int n;
        n = 0;
        acc = -1;
        @(negedge clk);
        while (!rdy[id] && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (n >= 50) begin
            checks++; fails++;
            $display("FAIL %s_ready_timeout actual=0 required=1", v.tag);
            return;
        end
        zero[id] = v.zero; ins[id] = v.instr; iv[id] = 1'b1;
        @(posedge clk);
        #1;
        acc = cyc;
        iv[id] = 1'b0;
        e = v.e;
        e.cyc = acc;
`ifdef ILLEGAL_TRAP_EN
        e.kind = v.illegal ? 2 : 0;
`else
        e.kind = 0;
`endif
        if (id == 0) q0.push_back(e); else q1.push_back(e);
        if (v.br) begin
            e.kind = 1;
            e.cyc = acc + ((id == 0) ? 1 : 3);
            e.tag = {v.tag, "_br"};
            if (id == 0) q0.push_back(e); else q1.push_back(e);
        end
    endtask

    // Monitor: pop and compare whenever a dut presents an event.
    task automatic mon(input int id);
        item_t e;
        int k;
        if (!(isv[id] | bv[id] | ill[id])) begin
            chk($sformatf("d%0d_idle_strobes", id), {29'd0, rw[id], mr[id], mw[id]}, 32'd0);
            return;
        end
        k = bv[id] ? 1 : (ill[id] ? 2 : 0);
        if ((id == 0 && q0.size() == 0) || (id == 1 && q1.size() == 0)) begin
            checks++; fails++;
            $display("FAIL d%0d_unexpected_event kind actual=%0d required=none", id, k);
            return;
        end
        if (id == 0) e = q0.pop_front(); else e = q1.pop_front();
        chk({e.tag, "_kind"}, k, e.kind);
        chk({e.tag, "_cycle"}, cyc, e.cyc);
        if (e.kind == 0) begin
            chk({e.tag, "_alu"}, {28'd0, alu[id]}, {28'd0, e.alu});
            chk({e.tag, "_alusrc"}, {31'd0, src[id]}, {31'd0, e.src});
            chk({e.tag, "_rn_rm_rd"}, {17'd0, rn[id], rm[id], rd[id]}, {17'd0, e.rn, e.rm, e.rd});
            chk({e.tag, "_strobes"}, {29'd0, rw[id], mr[id], mw[id]}, {29'd0, e.rw, e.mr, e.mw});
            if (e.chk_se) chk({e.tag, "_sign_extend"}, se[id], e.se);
        end else if (e.kind == 1) begin
            chk({e.tag, "_taken"}, {31'd0, bt[id]}, {31'd0, e.taken});
            chk({e.tag, "_offset"}, bo[id], e.off);
        end else begin
            chk({e.tag, "_no_issue"}, {28'd0, isv[id], rw[id], mr[id], mw[id]}, 32'd0);
        end
    endtask

    always @(negedge clk) if (rst_n) mon(0);
    always @(negedge clk) if (rst_n) mon(1);

    initial begin
        int acc;
        int prev;
        int n;
        rst_n = 1'b0; iv = 2'b00; zero = 2'b00; ins[0] = 32'd0; ins[1] = 32'd0;
        //       tag     instr         z     ill   br    alu      src   se            cse   rn     rm     rd     rw    mr    mw    tk    off
        add_vec("add",  32'h8B020023, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b0, 32'h0,        1'b0, 5'd1,  5'd2,  5'd3,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add_vec("addi", 32'h91001441, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 32'h00000005, 1'b1, 5'd2,  5'd0,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add_vec("sub",  32'hCB0700C5, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b0, 32'h0,        1'b0, 5'd6,  5'd7,  5'd5,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add_vec("and",  32'h8A030041, 1'b0, 1'b0, 1'b0, 4'b0110, 1'b0, 32'h0,        1'b0, 5'd2,  5'd3,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add_vec("orr",  32'hAA030041, 1'b0, 1'b0, 1'b0, 4'b0100, 1'b0, 32'h0,        1'b0, 5'd2,  5'd3,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add_vec("eor",  32'hCA030041, 1'b0, 1'b0, 1'b0, 4'b1001, 1'b0, 32'h0,        1'b0, 5'd2,  5'd3,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add_vec("subi", 32'hD13FFC62, 1'b0, 1'b0, 1'b0, 4'b1010, 1'b1, 32'h00000FFF, 1'b1, 5'd3,  5'd0,  5'd2,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add_vec("ldur", 32'hF85F8149, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 32'hFFFFFFF8, 1'b1, 5'd10, 5'd0,  5'd9,  1'b1, 1'b1, 1'b0, 1'b0, 32'h0);
        add_vec("stur", 32'hF801018B, 1'b0, 1'b0, 1'b0, 4'b0010, 1'b1, 32'h00000010, 1'b1, 5'd12, 5'd11, 5'd0,  1'b0, 1'b0, 1'b1, 1'b0, 32'h0);
        add_vec("movz", 32'hD29579A1, 1'b0, 1'b0, 1'b0, 4'b1101, 1'b1, 32'h0000ABCD, 1'b1, 5'd0,  5'd0,  5'd1,  1'b1, 1'b0, 1'b0, 1'b0, 32'h0);
        add_vec("cbz",  32'hB4FFFFC4, 1'b1, 1'b0, 1'b1, 4'b0111, 1'b0, 32'hFFFFFFFE, 1'b1, 5'd4,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b1, 32'hFFFFFFF8);
        add_vec("cbnz", 32'hB5000067, 1'b0, 1'b0, 1'b1, 4'b0001, 1'b0, 32'h00000003, 1'b1, 5'd7,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0000000C);
        add_vec("zero", 32'h00000000, 1'b0, 1'b1, 1'b0, 4'b0000, 1'b0, 32'h0,        1'b1, 5'd0,  5'd0,  5'd0,  1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
        repeat (2) @(negedge clk);
        chk_reset(0, "reset_d0");
        chk_reset(1, "reset_d1");
        rst_n = 1'b1;

        // Directed vectors on the ZERO_LAT=1 instance; the first two go back to back.
        prev = -1;
        foreach (vq[i]) begin
            send(0, vq[i], acc);
            if (i == 1) chk("b2b_accept_gap", acc - prev, 32'd2);
            prev = acc;
        end

        // CBZ with ZERO_LAT=3 and Zero=0; Instr_ready stays low until RESOLVE is over.
        add_vec("cbz3", 32'hB4FFFFC4, 1'b0, 1'b0, 1'b1, 4'b0111, 1'b0, 32'hFFFFFFFE, 1'b1, 5'd4, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 32'hFFFFFFF8);
        send(1, vq[vq.size()-1], acc);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk($sformatf("cbz3_ready_low_c%0d", k), {31'd0, rdy[1]}, 32'd0);
        end
        @(negedge clk);
        chk("cbz3_ready_after", {31'd0, rdy[1]}, 32'd1);

        // Reset while dut 1 sits in WAIT: outputs clear at once and the branch never resolves.
        send(1, vq[vq.size()-1], acc);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset(1, "rst_mid_wait");
        q1.delete();
        @(negedge clk);
        rst_n = 1'b1;
        chk("rst_release_ready", {31'd0, rdy[1]}, 32'd1);
        repeat (6) @(negedge clk);

        n = 0;
        while ((q0.size() != 0 || q1.size() != 0) && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("scoreboard_drained", q0.size() + q1.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
